// File: rtl/hazard_forward_unit.sv
// Combined load-use hazard detection, branch flush control and EX-stage operand
// forwarding for the 5-stage pipeline, with saturating stall/flush debug counters.
module hazard_forward_unit #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         idex_dst,
    input  logic                          idex_memRead,
    input  logic                          idex_regWrite,
    input  logic [REG_ADDR_W-1:0]         exmem_dst,
    input  logic                          exmem_regWrite,
    input  logic [REG_ADDR_W-1:0]         memwb_dst,
    input  logic                          memwb_regWrite,
    input  logic                          branch_taken,
    output logic                          pc_write,
    output logic                          ifid_write,
    output logic                          idex_bubble,
    output logic [FLUSH_DEPTH-1:0]        flush_vec,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic [CNT_W-1:0]              stall_count,
    output logic [CNT_W-1:0]              flush_count
);

    localparam int unsigned STALL_CNT_W = 3;
    localparam int unsigned SRC_W       = NUM_SRC * REG_ADDR_W;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    state_e                 state_q,       state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
    logic [SRC_W-1:0]       ex_src_q,      ex_src_d;
    logic [NUM_SRC-1:0]     ex_used_q,     ex_used_d;
    logic [CNT_W-1:0]       stall_count_q, stall_count_d;
    logic [CNT_W-1:0]       flush_count_q, flush_count_d;
    logic                   hazard;
    logic                   advance;

    // Load in ID/EX whose destination is read by the instruction in IF/ID.
    always_comb begin
        hazard = 1'b0;
        if (idex_memRead && idex_regWrite && (idex_dst != '0)) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (id_src_used[k] && (id_src[k*REG_ADDR_W +: REG_ADDR_W] == idex_dst)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Stall/flush FSM; a taken branch overrides any pending stall.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_vec   = '0;
        if (reset) begin
            state_d     = ST_RUN;
            stall_cnt_d = '0;
        end else if (branch_taken) begin
            flush_vec   = '1;
            state_d     = ST_RUN;
            stall_cnt_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d     = ST_STALL;
                            stall_cnt_d = STALL_CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                ST_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
                    if (stall_cnt_q == STALL_CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    stall_cnt_d = '0;
                end
            endcase
        end
    end

    // Shadow of the operands entering EX; a bubble or flush leaves no live operands.
    always_comb begin
        advance   = pc_write && !flush_vec[0];
        ex_src_d  = ex_src_q;
        ex_used_d = '0;
        if (advance) begin
            ex_src_d  = id_src;
            ex_used_d = id_src_used;
        end
    end

    // EX/MEM has the younger result, so it takes priority over MEM/WB.
    always_comb begin
        logic [REG_ADDR_W-1:0] src;
        src     = '0;
        fwd_sel = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            src = ex_src_q[k*REG_ADDR_W +: REG_ADDR_W];
            if (!reset && ex_used_q[k] && (src != '0)) begin
                if (exmem_regWrite && (exmem_dst == src)) begin
                    fwd_sel[2*k +: 2] = 2'd1;
                end else if (memwb_regWrite && (memwb_dst == src)) begin
                    fwd_sel[2*k +: 2] = 2'd2;
                end
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pc_write && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        if (branch_taken && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            stall_cnt_q   <= '0;
            ex_src_q      <= '0;
            ex_used_q     <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            ex_src_q      <= ex_src_d;
            ex_used_q     <= ex_used_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: three parameterisations share one stimulus stream
// and are compared against a cycle-level model built on remaining-stall counts.
module tb_hazard_forward_unit;

    logic        clock;
    logic        reset;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  idex_dst;
    logic        idex_memRead;
    logic        idex_regWrite;
    logic [4:0]  exmem_dst;
    logic        exmem_regWrite;
    logic [4:0]  memwb_dst;
    logic        memwb_regWrite;
    logic        branch_taken;

    logic        pcw [3];
    logic        ifw [3];
    logic        bub [3];
    logic [3:0]  fwd [3];
    logic [1:0]  fv0, fv1;
    logic [2:0]  fv2;
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [1:0]  sc2, fc2;
    logic [2:0]  fv [3];
    logic [15:0] sc [3];
    logic [15:0] fc [3];

    assign fv[0] = {1'b0, fv0};
    assign fv[1] = {1'b0, fv1};
    assign fv[2] = fv2;
    assign sc[0] = sc0;
    assign sc[1] = sc1;
    assign sc[2] = {14'd0, sc2};
    assign fc[0] = fc0;
    assign fc[1] = fc1;
    assign fc[2] = {14'd0, fc2};

    hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .FLUSH_DEPTH(2), .CNT_W(16)) u_d0 (
        .clock(clock), .reset(reset), .id_src(id_src), .id_src_used(id_src_used),
        .idex_dst(idex_dst), .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
        .exmem_dst(exmem_dst), .exmem_regWrite(exmem_regWrite),
        .memwb_dst(memwb_dst), .memwb_regWrite(memwb_regWrite), .branch_taken(branch_taken),
        .pc_write(pcw[0]), .ifid_write(ifw[0]), .idex_bubble(bub[0]), .flush_vec(fv0),
        .fwd_sel(fwd[0]), .stall_count(sc0), .flush_count(fc0));

    hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(16)) u_d1 (
        .clock(clock), .reset(reset), .id_src(id_src), .id_src_used(id_src_used),
        .idex_dst(idex_dst), .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
        .exmem_dst(exmem_dst), .exmem_regWrite(exmem_regWrite),
        .memwb_dst(memwb_dst), .memwb_regWrite(memwb_regWrite), .branch_taken(branch_taken),
        .pc_write(pcw[1]), .ifid_write(ifw[1]), .idex_bubble(bub[1]), .flush_vec(fv1),
        .fwd_sel(fwd[1]), .stall_count(sc1), .flush_count(fc1));

    hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(2), .FLUSH_DEPTH(3), .CNT_W(2)) u_d2 (
        .clock(clock), .reset(reset), .id_src(id_src), .id_src_used(id_src_used),
        .idex_dst(idex_dst), .idex_memRead(idex_memRead), .idex_regWrite(idex_regWrite),
        .exmem_dst(exmem_dst), .exmem_regWrite(exmem_regWrite),
        .memwb_dst(memwb_dst), .memwb_regWrite(memwb_regWrite), .branch_taken(branch_taken),
        .pc_write(pcw[2]), .ifid_write(ifw[2]), .idex_bubble(bub[2]), .flush_vec(fv2),
        .fwd_sel(fwd[2]), .stall_count(sc2), .flush_count(fc2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model state: remaining forced stall cycles after the current one, EX shadow, counters.
    int         m_rem [3];
    logic [4:0] m_src [3][2];
    logic       m_used [3][2];
    int         m_st [3];
    int         m_fl [3];
    logic       m_stalled [3];
    logic       exp_pc [3];
    logic [2:0] exp_fv [3];
    logic [3:0] exp_fwd [3];

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic int cmax_of(int d);
        return (d == 2) ? 3 : 65535;
    endfunction

    task automatic model_comb();
        logic hz;
        logic [1:0] f;
        hz = 1'b0;
        if (idex_memRead && idex_regWrite && idex_dst != 5'd0)
            for (int k = 0; k < 2; k++)
                if (id_src_used[k] && id_src[k*5 +: 5] == idex_dst) hz = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m_stalled[d] = !reset && !branch_taken && (m_rem[d] > 0 || hz);
            exp_pc[d]    = !m_stalled[d];
            exp_fv[d]    = (!reset && branch_taken) ? ((d == 2) ? 3'b111 : 3'b011) : 3'b000;
            for (int k = 0; k < 2; k++) begin
                f = 2'd0;
                if (!reset && m_used[d][k] === 1'b1 && m_src[d][k] != 5'd0) begin
                    if (exmem_regWrite && exmem_dst == m_src[d][k]) f = 2'd1;
                    else if (memwb_regWrite && memwb_dst == m_src[d][k]) f = 2'd2;
                end
                exp_fwd[d][2*k +: 2] = f;
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_rem[d] = 0; m_st[d] = 0; m_fl[d] = 0;
                for (int k = 0; k < 2; k++) begin m_src[d][k] = 5'd0; m_used[d][k] = 1'b0; end
            end else if (branch_taken) begin
                m_rem[d] = 0;
                m_fl[d]  = (m_fl[d] + 1 > cmax_of(d)) ? cmax_of(d) : m_fl[d] + 1;
                for (int k = 0; k < 2; k++) m_used[d][k] = 1'b0;
            end else if (m_stalled[d]) begin
                m_rem[d] = (m_rem[d] > 0) ? m_rem[d] - 1 : lat_of(d) - 1;
                m_st[d]  = (m_st[d] + 1 > cmax_of(d)) ? cmax_of(d) : m_st[d] + 1;
                for (int k = 0; k < 2; k++) m_used[d][k] = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    m_src[d][k]  = id_src[k*5 +: 5];
                    m_used[d][k] = id_src_used[k];
                end
            end
        end
    endtask

    task automatic tick();
        model_comb();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        id_src = 10'd0; id_src_used = 2'b00;
        idex_dst = 5'd0; idex_memRead = 1'b0; idex_regWrite = 1'b0;
        exmem_dst = 5'd0; exmem_regWrite = 1'b0;
        memwb_dst = 5'd0; memwb_regWrite = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic rand_inputs();
        id_src         = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
        id_src_used    = 2'($urandom_range(0, 3));
        idex_dst       = 5'($urandom_range(0, 3));
        idex_memRead   = 1'($urandom_range(0, 1));
        idex_regWrite  = ($urandom_range(0, 3) != 0);
        exmem_dst      = 5'($urandom_range(0, 3));
        exmem_regWrite = 1'($urandom_range(0, 1));
        memwb_dst      = 5'($urandom_range(0, 3));
        memwb_regWrite = 1'($urandom_range(0, 1));
        branch_taken   = ($urandom_range(0, 7) == 0);
    endtask

    task automatic pulse_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rand_inputs();
        reset = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                rand_inputs();
                idex_memRead = 1'b1; idex_regWrite = 1'b1;
                idex_dst = id_src[4:0]; id_src_used = 2'b11;
                branch_taken = (c == 1);
            end else begin
                set_idle();
            end
            reset = (c < 3);
            #1;
            model_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (pcw[d] !== exp_pc[d] || ifw[d] !== exp_pc[d] || bub[d] !== !exp_pc[d]) begin
                    errors++;
                    $display("FAIL reset_ctl dut%0d cyc%0d: pc=%b ifid=%b bubble=%b, expected pc=%b", d, c, pcw[d], ifw[d], bub[d], exp_pc[d]);
                end
                checks++;
                if (fv[d] !== exp_fv[d] || fwd[d] !== exp_fwd[d]) begin
                    errors++;
                    $display("FAIL reset_out dut%0d cyc%0d: flush_vec=%b fwd_sel=%b, expected %b %b", d, c, fv[d], fwd[d], exp_fv[d], exp_fwd[d]);
                end
                checks++;
                if (sc[d] !== 16'(m_st[d]) || fc[d] !== 16'(m_fl[d])) begin
                    errors++;
                    $display("FAIL reset_cnt dut%0d cyc%0d: stall=%0d flush=%0d, expected %0d %0d", d, c, sc[d], fc[d], m_st[d], m_fl[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        pulse_reset();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            id_src = {5'd3, 5'd8}; id_src_used = 2'b01;
            if (c == 0) begin
                idex_dst = 5'd8; idex_memRead = 1'b1; idex_regWrite = 1'b1;
            end
            #1;
            model_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (pcw[d] !== exp_pc[d] || ifw[d] !== exp_pc[d] || bub[d] !== !exp_pc[d]) begin
                    errors++;
                    $display("FAIL load_use_ctl dut%0d cyc%0d: pc=%b ifid=%b bubble=%b, expected pc=%b", d, c, pcw[d], ifw[d], bub[d], exp_pc[d]);
                end
                checks++;
                if (sc[d] !== 16'(m_st[d])) begin
                    errors++;
                    $display("FAIL load_use_cnt dut%0d cyc%0d: stall_count=%0d, expected %0d", d, c, sc[d], m_st[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_forward();
        pulse_reset();
        for (int c = 0; c < 7; c++) begin
            set_idle();
            id_src = {5'd5, 5'd9}; id_src_used = 2'b10;
            case (c)
                1: begin exmem_dst = 5'd5; exmem_regWrite = 1'b1; memwb_dst = 5'd5; memwb_regWrite = 1'b1; end
                2: begin exmem_dst = 5'd5; exmem_regWrite = 1'b0; memwb_dst = 5'd5; memwb_regWrite = 1'b1; end
                3: begin exmem_dst = 5'd9; exmem_regWrite = 1'b1; id_src = 10'd0; id_src_used = 2'b11; end
                4, 5: begin exmem_regWrite = 1'b1; memwb_regWrite = 1'b1; id_src = 10'd0; id_src_used = 2'b11; end
                6: begin exmem_dst = 5'd5; memwb_dst = 5'd5; exmem_regWrite = 1'b1; memwb_regWrite = 1'b1; end
                default: ;
            endcase
            #1;
            model_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (fwd[d] !== exp_fwd[d]) begin
                    errors++;
                    $display("FAIL forward dut%0d cyc%0d: fwd_sel=%b, expected %b", d, c, fwd[d], exp_fwd[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_reg0_hazard();
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            set_idle();
            idex_dst = 5'd0; idex_memRead = 1'b1; idex_regWrite = 1'b1;
            id_src = 10'd0; id_src_used = 2'b11;
            #1;
            model_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (pcw[d] !== 1'b1 || bub[d] !== 1'b0 || pcw[d] !== exp_pc[d]) begin
                    errors++;
                    $display("FAIL reg0_hazard dut%0d cyc%0d: pc=%b bubble=%b, expected pc=1 bubble=0", d, c, pcw[d], bub[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush_mid_stall();
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            set_idle();
            id_src = {5'd0, 5'd7}; id_src_used = 2'b01;
            if (c == 0) begin idex_dst = 5'd7; idex_memRead = 1'b1; idex_regWrite = 1'b1; end
            branch_taken = (c == 1);
            #1;
            model_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (pcw[d] !== exp_pc[d] || ifw[d] !== exp_pc[d] || bub[d] !== !exp_pc[d] || fv[d] !== exp_fv[d]) begin
                    errors++;
                    $display("FAIL flush_ctl dut%0d cyc%0d: pc=%b bubble=%b flush_vec=%b, expected pc=%b flush_vec=%b", d, c, pcw[d], bub[d], fv[d], exp_pc[d], exp_fv[d]);
                end
                checks++;
                if (fc[d] !== 16'(m_fl[d]) || sc[d] !== 16'(m_st[d])) begin
                    errors++;
                    $display("FAIL flush_cnt dut%0d cyc%0d: flush=%0d stall=%0d, expected %0d %0d", d, c, fc[d], sc[d], m_fl[d], m_st[d]);
                end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int c = 0; c < 20; c++) begin
            set_idle();
            id_src = {5'd12, 5'd0}; id_src_used = 2'b10;
            if (c % 4 == 0) begin idex_dst = 5'd12; idex_memRead = 1'b1; idex_regWrite = 1'b1; end
            #1;
            model_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (sc[d] !== 16'(m_st[d]) || pcw[d] !== exp_pc[d]) begin
                    errors++;
                    $display("FAIL saturate dut%0d cyc%0d: stall_count=%0d pc=%b, expected %0d %b", d, c, sc[d], pcw[d], m_st[d], exp_pc[d]);
                end
            end
            tick();
        end
        checks++;
        if (sc[2] !== 16'd3) begin
            errors++;
            $display("FAIL saturate_hold: stall_count=%0d, expected 3", sc[2]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            reset = ($urandom_range(0, 49) == 0);
            #1;
            model_comb();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (pcw[d] !== exp_pc[d] || ifw[d] !== exp_pc[d] || bub[d] !== !exp_pc[d]) begin
                    errors++;
                    $display("FAIL random_ctl dut%0d cyc%0d: pc=%b ifid=%b bubble=%b, expected pc=%b", d, c, pcw[d], ifw[d], bub[d], exp_pc[d]);
                end
                checks++;
                if (fv[d] !== exp_fv[d] || fwd[d] !== exp_fwd[d]) begin
                    errors++;
                    $display("FAIL random_out dut%0d cyc%0d: flush_vec=%b fwd_sel=%b, expected %b %b", d, c, fv[d], fwd[d], exp_fv[d], exp_fwd[d]);
                end
                checks++;
                if (sc[d] !== 16'(m_st[d]) || fc[d] !== 16'(m_fl[d])) begin
                    errors++;
                    $display("FAIL random_cnt dut%0d cyc%0d: stall=%0d flush=%0d, expected %0d %0d", d, c, sc[d], fc[d], m_st[d], m_fl[d]);
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_rem[d] = 0; m_st[d] = 0; m_fl[d] = 0;
            for (int k = 0; k < 2; k++) begin m_src[d][k] = 5'd0; m_used[d][k] = 1'b0; end
        end
        set_idle();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_forward();
        test_reg0_hazard();
        test_flush_mid_stall();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard-detection and forwarding controller for the 5-stage pipeline. It replaces the separate hazard and forwarding blocks with one unit. It tracks the source-register indices of the instruction moving from IF/ID into ID/EX, and produces per-operand forwarding selects for the EX stage. It stalls on load-use for a configurable number of cycles, flushes a configurable number of front-end stage registers on a taken branch, and keeps saturating stall and flush counters for debug.

## Interface
- REG_ADDR_W, 5, register index width
- NUM_SRC, 2, source operands per instruction; operand 0 = rs, 1 = rt, 2+ = extra ports
- LOAD_LAT, 1, stall cycles per load-use hazard, legal 1..7
- FLUSH_DEPTH, 2, number of stage registers cleared on a taken branch
- CNT_W, 16, width of the statistics counters

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_src  in  NUM_SRC*REG_ADDR_W  source indices of the IF/ID instruction; operand k at [k*REG_ADDR_W +: REG_ADDR_W]
- id_src_used  in  NUM_SRC  operand k actually read by the IF/ID instruction
- idex_dst  in  REG_ADDR_W  destination of the ID/EX instruction
- idex_memRead  in  1  ID/EX instruction is a load
- idex_regWrite  in  1  ID/EX instruction writes a register
- exmem_dst / exmem_regWrite  in  REG_ADDR_W / 1  EX/MEM destination and write enable
- memwb_dst / memwb_regWrite  in  REG_ADDR_W / 1  MEM/WB destination and write enable
- branch_taken  in  1  branch resolved taken in MEM this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_bubble  out  1  force the ID/EX control fields to zero
- flush_vec  out  FLUSH_DEPTH  bit i clears stage register i (0 = IF/ID, 1 = ID/EX, ...)
- fwd_sel  out  2*NUM_SRC  per operand: 0 = register file, 1 = EX/MEM, 2 = MEM/WB
- stall_count  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of flush events

## Operation
- States: RUN and STALL; stall_cnt is 3 bits wide.
- hazard = idex_memRead & idex_regWrite & idex_dst != 0 & (any k: id_src_used[k] & id_src[k] == idex_dst).
- **RUN:**
  - If hazard and not branch_taken: pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - In that case, if LOAD_LAT > 1, go to STALL with stall_cnt = LOAD_LAT-1; otherwise stay in RUN.
- **STALL:**
  - pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - Decrement stall_cnt each cycle; return to RUN when stall_cnt == 1 at the clock edge.
- **branch_taken (any state):**
  - flush_vec = all ones for that cycle, pc_write = 1, ifid_write = 1, idex_bubble = 0.
  - The state returns to RUN and stall_cnt is cleared; a flush overrides any stall.
- **Shadow EX operands:** registers ex_src and ex_used.
  - On each edge with ifid advancing (pc_write = 1 and no flush_vec[0]): load ex_src from id_src and ex_used from id_src_used.
  - On a bubble or flush: ex_used is cleared to 0.
- **Forwarding,** combinational from the shadow registers, for each operand k with ex_used[k] and ex_src[k] != 0:
  - 1 if exmem_regWrite and exmem_dst == ex_src[k];
  - else 2 if memwb_regWrite and memwb_dst == ex_src[k];
  - else 0. EX/MEM wins when both stages match.
- **Counters:**
  - stall_count increments every cycle pc_write = 0.
  - flush_count increments on every cycle branch_taken = 1.
  - Both saturate at all ones.

## Timing
- Hazard and flush outputs are combinational from inputs and state, in the same cycle as the hazard is present. State, shadow registers and counters update on the rising edge.
- A load-use hazard produces exactly LOAD_LAT consecutive cycles with pc_write = 0, starting in the detection cycle.
- fwd_sel reflects the shadow registers loaded at the previous edge (zero added latency for the EX stage).
- While reset = 1 and on the cycle after its release:
  - state = RUN, stall_cnt = 0, ex_src = 0, ex_used = 0, counters = 0;
  - outputs pc_write = 1, ifid_write = 1, idex_bubble = 0, flush_vec = 0, fwd_sel = 0.
- Reset asserted mid-STALL aborts the stall at that edge.
- Register 0 is never a hazard and never forwarded.

## Test plan
- LOAD_LAT = 1: load to r8 in ID/EX, IF/ID reads rs = r8 -> one cycle pc_write = 0, idex_bubble = 1, stall_count = 1.
- LOAD_LAT = 3: same hazard -> pc_write low for exactly 3 cycles, stall_count = 3, then RUN resumes.
- Forwarding priority: ex_src rt = r5, exmem_dst = memwb_dst = r5, both regWrite -> fwd_sel[3:2] = 1. Drop exmem_regWrite -> 2.
- Register 0: load to r0 with use of r0 -> no stall. ex_src = 0 with exmem_dst = 0 -> fwd_sel = 0.
- Flush during the second stall cycle (LOAD_LAT = 3) -> flush_vec = 2'b11, pc_write = 1 that cycle, RUN on the next cycle, flush_count = 1.
- CNT_W = 2: five load-use stalls -> stall_count holds at 3.
